// File: rtl/serial_pattern_tx_pkg.sv
// Shared constants for the serial pattern transmitter: FSM encoding,
// seven-segment codes (active-low, dp g f e d c b a) and digit enables.
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] AN_D0  = 8'b1111_1110;
  localparam logic [7:0] AN_D1  = 8'b1111_1101;
  localparam logic [7:0] AN_OFF = 8'hFF;

endpackage

// File: rtl/serial_pattern_tx_seg_hex_enc.sv
// Combinational hex digit to seven-segment code, with a blank override.
module seg_hex_enc
  import serial_pattern_tx_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (value)
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        4'hF: seg = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a 16-bit switch pattern out MSB first,
// one bit per 2^PARA clocks, with a tick per new bit and a 2-digit display.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int PARA = 24,
  parameter int SCAN = 16,
  parameter int LEN  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [LEN-1:0] sw_i,
  input  logic           start_i,
  input  logic           loop_i,
  output logic           bit_o,
  output logic           valid_o,
  output logic           tick_o,
  output logic [LEN-1:0] led_o,
  output logic [7:0]     disp_seg_o,
  output logic [7:0]     disp_an_o
);

  localparam int IW = $clog2(LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

  state_t          state, state_next;
  logic            sync1, sync2, start_p;
  logic [PARA-1:0] bit_cnt, bit_cnt_next;
  logic [LEN-1:0]  shreg, shreg_next;
  logic [IW-1:0]   idx, idx_next;
  logic            bit_next, valid_next, tick_next;
  logic            end_of_bit, load, shift, reload, pat_end;
  logic [SCAN:0]   scan_cnt;
  logic            digit_sel;
  logic [3:0]      disp_val;
  logic [7:0]      seg_code;

  // Sync flops reset high so a button held through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= start_i;
      sync2 <= sync1;
    end
  end

  assign start_p    = sync1 & ~sync2;
  assign end_of_bit = (state == RUN) && (bit_cnt == '1);
  assign load       = start_p;
  assign shift      = !start_p && end_of_bit && (idx != LAST_IDX);
  assign reload     = !start_p && end_of_bit && (idx == LAST_IDX) && loop_i;
  assign pat_end    = !start_p && end_of_bit && (idx == LAST_IDX) && !loop_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start_p)      state_next = RUN;
    else if (pat_end) state_next = DONE;
  end

  always_comb begin
    shreg_next   = shreg;
    idx_next     = idx;
    bit_cnt_next = bit_cnt;
    bit_next     = bit_o;
    valid_next   = valid_o;
    tick_next    = 1'b0;
    if (state == RUN) bit_cnt_next = bit_cnt + 1'b1;
    if (load || reload) begin
      shreg_next   = sw_i;
      idx_next     = '0;
      bit_cnt_next = '0;
      bit_next     = sw_i[LEN-1];
      valid_next   = 1'b1;
      tick_next    = 1'b1;
    end else if (shift) begin
      shreg_next = {shreg[LEN-2:0], 1'b0};
      idx_next   = idx + 1'b1;
      bit_next   = shreg[LEN-2];
      tick_next  = 1'b1;
    end else if (pat_end) begin
      valid_next = 1'b0;
      bit_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      idx     <= '0;
      bit_cnt <= '0;
      bit_o   <= 1'b0;
      valid_o <= 1'b0;
      tick_o  <= 1'b0;
    end else begin
      shreg   <= shreg_next;
      idx     <= idx_next;
      bit_cnt <= bit_cnt_next;
      bit_o   <= bit_next;
      valid_o <= valid_next;
      tick_o  <= tick_next;
    end
  end

  assign led_o = (state == RUN) ? shreg : '0;

  // Digit 0 shows the current bit, digit 1 the bit index.
  assign digit_sel = scan_cnt[SCAN];
  assign disp_val  = digit_sel ? 4'(idx) : {3'b000, bit_o};

  seg_hex_enc u_seg_hex_enc (
    .value (disp_val),
    .blank (state != RUN),
    .seg   (seg_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt   <= '0;
      disp_an_o  <= AN_OFF;
      disp_seg_o <= SEG_BLANK;
    end else begin
      scan_cnt   <= scan_cnt + 1'b1;
      disp_an_o  <= digit_sel ? AN_D1 : AN_D0;
      disp_seg_o <= seg_code;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx with PARA=3 (8-clk bits) and SCAN=2.
module tb_serial_pattern_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_i;
  logic        start_i;
  logic        loop_i;
  logic        bit_o, valid_o, tick_o;
  logic [15:0] led_o;
  logic [7:0]  disp_seg_o, disp_an_o;

  serial_pattern_tx #(.PARA(3), .SCAN(2), .LEN(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_i       (sw_i),
    .start_i    (start_i),
    .loop_i     (loop_i),
    .bit_o      (bit_o),
    .valid_o    (valid_o),
    .tick_o     (tick_o),
    .led_o      (led_o),
    .disp_seg_o (disp_seg_o),
    .disp_an_o  (disp_an_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exp_bit;
    logic [15:0] exp_led;
    logic [7:0]  exp_seg_idx;
  } vec_t;

  vec_t tbl[16];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    step(2);
    start_i = 1'b0;
  endtask

  task automatic check_disp(input logic b, input logic [7:0] idx_code);
    check("disp_an", 32'((disp_an_o == 8'hFE) || (disp_an_o == 8'hFD)), 1);
    if (disp_an_o == 8'hFD) check("disp_seg_idx", 32'(disp_seg_o), 32'(idx_code));
    else                    check("disp_seg_bit", 32'(disp_seg_o), b ? 32'hF9 : 32'hC0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bit"},   32'(bit_o), 0);
    check({tag, "_valid"}, 32'(valid_o), 0);
    check({tag, "_tick"},  32'(tick_o), 0);
    check({tag, "_led"},   32'(led_o), 0);
    check({tag, "_seg"},   32'(disp_seg_o), 32'hFF);
    check({tag, "_an"},    32'(disp_an_o), 32'hFF);
    check({tag, "_state"}, 32'(dut.state), 0);
    check({tag, "_idx"},   32'(dut.idx), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    logic [2:0] hist;
    int ndet, det_k, nfe, nfd;
    tbl[0]  = '{1'b1, 16'hA000, 8'hC0};
    tbl[1]  = '{1'b0, 16'h4000, 8'hF9};
    tbl[2]  = '{1'b1, 16'h8000, 8'hA4};
    tbl[3]  = '{1'b0, 16'h0000, 8'hB0};
    tbl[4]  = '{1'b0, 16'h0000, 8'h99};
    tbl[5]  = '{1'b0, 16'h0000, 8'h92};
    tbl[6]  = '{1'b0, 16'h0000, 8'h82};
    tbl[7]  = '{1'b0, 16'h0000, 8'hF8};
    tbl[8]  = '{1'b0, 16'h0000, 8'h80};
    tbl[9]  = '{1'b0, 16'h0000, 8'h90};
    tbl[10] = '{1'b0, 16'h0000, 8'h88};
    tbl[11] = '{1'b0, 16'h0000, 8'h83};
    tbl[12] = '{1'b0, 16'h0000, 8'hC6};
    tbl[13] = '{1'b0, 16'h0000, 8'hA1};
    tbl[14] = '{1'b0, 16'h0000, 8'h86};
    tbl[15] = '{1'b0, 16'h0000, 8'h8E};

    // Reset, with the button held across release.
    rst = 1'b1; start_i = 1'b0; loop_i = 1'b0; sw_i = 16'h0000;
    #2;
    check_reset_vals("rst");
    start_i = 1'b1;
    step(2);
    rst = 1'b0;
    step(5);
    check("held_valid", 32'(valid_o), 0);
    check("held_state", 32'(dut.state), 0);
    check("held_tick",  32'(tick_o), 0);
    start_i = 1'b0;
    step(3);

    // Single pattern A000, table driven per bit, with a 101 detector model.
    sw_i = 16'hA000; loop_i = 1'b0;
    hist = 3'b000; ndet = 0; det_k = -1;
    start_pulse();
    for (int k = 0; k < 16; k++) begin
      check("t2_tick",  32'(tick_o), 1);
      check("t2_valid", 32'(valid_o), 1);
      check("t2_bit",   32'(bit_o), 32'(tbl[k].exp_bit));
      check("t2_led",   32'(led_o), 32'(tbl[k].exp_led));
      if (tick_o) begin
        hist = {hist[1:0], bit_o};
        if (hist == 3'b101) begin
          ndet++;
          det_k = k;
        end
      end
      for (int j = 1; j < 8; j++) begin
        step(1);
        check("t2_tick_low", 32'(tick_o), 0);
        check_disp(tbl[k].exp_bit, tbl[k].exp_seg_idx);
      end
      step(1);
    end
    check("t2_end_valid", 32'(valid_o), 0);
    check("t2_end_bit",   32'(bit_o), 0);
    check("t2_end_tick",  32'(tick_o), 0);
    check("t2_end_led",   32'(led_o), 0);
    check("t2_end_state", 32'(dut.state), 2);
    check("det_count",    32'(ndet), 1);
    check("det_bit",      32'(det_k), 2);
    step(1);
    check("t2_done_seg",  32'(disp_seg_o), 32'hFF);

    // Loop mode: reload picks up the switch value changed mid-pattern.
    sw_i = 16'h8001; loop_i = 1'b1;
    start_pulse();
    for (int k = 0; k < 16; k++) begin
      check("t3_tick", 32'(tick_o), 1);
      check("t3_bit",  32'(bit_o), 32'((k == 0) || (k == 15)));
      check("t3_idx",  32'(dut.idx), 32'(k));
      if (k == 10) sw_i = 16'hFFFF;
      for (int j = 1; j < 8; j++) begin
        step(1);
        check("t3_valid", 32'(valid_o), 1);
        check("t3_tick_low", 32'(tick_o), 0);
      end
      step(1);
    end
    check("t3_rl_tick",  32'(tick_o), 1);
    check("t3_rl_valid", 32'(valid_o), 1);
    check("t3_rl_bit",   32'(bit_o), 1);
    check("t3_rl_idx",   32'(dut.idx), 0);
    check("t3_rl_led",   32'(led_o), 32'hFFFF);
    step(8);
    check("t3_b1_led",   32'(led_o), 32'hFFFE);
    check("t3_b1_idx",   32'(dut.idx), 1);

    // Restart mid-bit at idx 5.
    sw_i = 16'h1234;
    step(32);
    check("t4_pre_idx", 32'(dut.idx), 5);
    step(2);
    start_pulse();
    check("t4_tick",  32'(tick_o), 1);
    check("t4_idx",   32'(dut.idx), 0);
    check("t4_bit",   32'(bit_o), 0);
    check("t4_led",   32'(led_o), 32'h1234);
    check("t4_valid", 32'(valid_o), 1);

    // Restart edge coincident with end of bit 5.
    sw_i = 16'hC3A5;
    step(40);
    check("t4c_pre_idx", 32'(dut.idx), 5);
    step(6);
    start_pulse();
    check("t4c_idx",  32'(dut.idx), 0);
    check("t4c_tick", 32'(tick_o), 1);
    check("t4c_bit",  32'(bit_o), 1);
    check("t4c_led",  32'(led_o), 32'hC3A5);
    step(7);
    check("t4c_mid_tick", 32'(tick_o), 0);
    check("t4c_mid_idx",  32'(dut.idx), 0);
    step(1);
    check("t4c_nx_tick", 32'(tick_o), 1);
    check("t4c_nx_idx",  32'(dut.idx), 1);

    // Asynchronous reset mid-run at idx 7, checked between clock edges.
    step(48);
    check("t5_pre_idx", 32'(dut.idx), 7);
    #2 rst = 1'b1;
    #1 check_reset_vals("t5_async");
    #2 rst = 1'b0;
    step(3);
    check("t5_idle_state", 32'(dut.state), 0);
    sw_i = 16'hA000; loop_i = 1'b0;
    start_pulse();
    check("t5_tick", 32'(tick_o), 1);
    check("t5_bit",  32'(bit_o), 1);
    check("t5_idx",  32'(dut.idx), 0);
    check("t5_led",  32'(led_o), 32'hA000);
    step(3);

    // Display multiplexing at idx 3 with bit 1.
    sw_i = 16'h1000;
    start_pulse();
    check("t6_bit0", 32'(bit_o), 0);
    step(24);
    check("t6_bit",  32'(bit_o), 1);
    check("t6_idx",  32'(dut.idx), 3);
    nfe = 0; nfd = 0;
    for (int j = 0; j < 8; j++) begin
      step(1);
      if (disp_an_o == 8'hFE) begin
        nfe++;
        check("t6_seg_d0", 32'(disp_seg_o), 32'hF9);
      end else if (disp_an_o == 8'hFD) begin
        nfd++;
        check("t6_seg_d1", 32'(disp_seg_o), 32'hB0);
      end else begin
        check("t6_an", 32'(disp_an_o), 32'hFE);
      end
    end
    check("t6_n_d0", 32'(nfe), 4);
    check("t6_n_d1", 32'(nfd), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
